// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl_pkg
// Purpose  : Shared types and constants for the run-length controller:
//            FSM state encoding and report buffer depth.
// Revision : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // Number of run-length reports that can wait for the consumer
    localparam int RPT_DEPTH = 2;

    // Run-length sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SAT   = 2'd2
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/run_report_buf.sv
`default_nettype none
// ============================================================================
// Module   : run_report_buf
// Purpose  : Two-entry in-order report FIFO. All outputs are registered:
//            the head entry drives dout directly and holds its last value
//            when the buffer empties. A push into a full buffer without a
//            simultaneous pop is discarded and flagged with a one-cycle drop.
// Revision : 1.0 - initial release
// ============================================================================
module run_report_buf #(
    parameter int DATA_W = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              drop
);
    import run_ctrl_pkg::*;

    localparam int LVL_W = $clog2(RPT_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(RPT_DEPTH);

    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              do_pop;
    logic              do_push;

    // Accepted pop/push for this edge and the resulting occupancy
    always_comb begin
        do_pop    = pop && valid;
        do_push   = push && (!full || do_pop);
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage, registered status flags and drop pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            level <= '0;
            head  <= '0;
            tail  <= '0;
            valid <= 1'b0;
            full  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            level <= level_nxt;
            valid <= (level_nxt != '0);
            full  <= (level_nxt == LVL_FULL);
            drop  <= push && full && !do_pop;
            // Head advances from the tail when two entries were held,
            // otherwise takes new data when it is (about to be) free.
            if (do_pop && full) begin
                head <= tail;
            end else if (do_push && (!valid || do_pop)) begin
                head <= din;
            end
            // Tail is written whenever new data lands behind a live head
            if (do_push && (full || (valid && !do_pop))) begin
                tail <= din;
            end
        end
    end

    assign dout = head;

endmodule
`default_nettype wire

// File: rtl/run_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_count_ctrl
// Purpose  : Consecutive-ones run-length controller. Samples W on En
//            strobes, tracks a saturating run length, and reports each
//            finished run through a two-entry valid/ready buffer.
//            Optional saturation interrupt enabled by macro RUN_SAT_IRQ_EN;
//            without it Irq is tied low and IrqClr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module run_count_ctrl #(
    parameter int CNT_W   = 3,
    parameter int MAX_RUN = 4,
    parameter int MIN_RUN = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             W,
    output logic [CNT_W-1:0] Count,
    output logic             Sat,
    output logic [CNT_W-1:0] RunLen,
    output logic             RunValid,
    input  logic             RunReady,
    output logic             Drop,
    output logic             Irq,
    input  logic             IrqClr
);
    import run_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    run_state_t       state;
    run_state_t       state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] push_len;
    logic             push_req;
    logic             enter_sat;
    logic             rpt_full;
    logic             unused_sig;

    // Next state, next count and report request from the sampled bit
    always_comb begin
        state_nxt = state;
        count_nxt = Count;
        push_len  = Count;
        push_req  = 1'b0;
        enter_sat = 1'b0;
        if (En) begin
            case (state)
                ST_IDLE: begin
                    if (W) begin
                        count_nxt = ONE;
                        if (MAX_VAL == ONE) begin
                            state_nxt = ST_SAT;
                            enter_sat = 1'b1;
                        end else begin
                            state_nxt = ST_COUNT;
                        end
                    end else begin
                        count_nxt = '0;
                    end
                end
                ST_COUNT: begin
                    if (W) begin
                        count_nxt = Count + ONE;
                        if ((Count + ONE) == MAX_VAL) begin
                            state_nxt = ST_SAT;
                            enter_sat = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        count_nxt = '0;
                        push_req  = (Count >= MIN_VAL);
                        push_len  = Count;
                    end
                end
                ST_SAT: begin
                    if (W) begin
                        count_nxt = MAX_VAL;
                    end else begin
                        state_nxt = ST_IDLE;
                        count_nxt = '0;
                        push_req  = 1'b1;
                        push_len  = MAX_VAL;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // State, count and saturation flag registers; a run in flight at
    // reset is simply forgotten.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            Count <= '0;
            Sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            Count <= count_nxt;
            Sat   <= (state_nxt == ST_SAT);
        end
    end

    run_report_buf #(
        .DATA_W (CNT_W)
    ) u_report_buf (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push_req),
        .din   (push_len),
        .pop   (RunReady),
        .dout  (RunLen),
        .valid (RunValid),
        .full  (rpt_full),
        .drop  (Drop)
    );

`ifdef RUN_SAT_IRQ_EN
    // Sticky saturation interrupt; a new saturation beats a clear
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Irq <= 1'b0;
        end else if (enter_sat) begin
            Irq <= 1'b1;
        end else if (IrqClr) begin
            Irq <= 1'b0;
        end
    end
    assign unused_sig = rpt_full;
`else
    assign Irq        = 1'b0;
    assign unused_sig = ^{IrqClr, enter_sat, rpt_full};
`endif

endmodule
`default_nettype wire
